ice40_clock_ratio_monitor: RTL and testbench

Measures the period of a divided clock, such as the half or quarter clock from the ice40 divider, by sampling it as data in the fast source-clock domain. Edges are timed in source-clock cycles and compared against an expected division ratio. The block reports each measured period, a lock flag and a sticky error flag. It sits beside the divider as the consumer/checker end of the divided-clock path, for board bring-up and runtime health checks.

---
 rtl/clock_monitor_pkg.sv | 20 ++
 rtl/mon_edge_sync.sv | 32 +++
 rtl/ice40_clock_ratio_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_ice40_clock_ratio_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the divided-clock ratio monitor: FSM state encoding,
// match-counter width and the saturating-max constant helper.
package clock_monitor_pkg;

  // Width of the consecutive-match counter; LOCK_COUNT must fit (1..15).
  localparam int unsigned MatchCntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StMeasure,
    StLocked
  } mon_state_e;

  // All-ones value of a counter of the given width (used as saturation point).
  function automatic longint unsigned sat_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/mon_edge_sync.sv
// Synchronizer for an asynchronous monitored clock plus a registered
// rising-edge detector. mon_rise is a one-cycle strobe in the clock_in domain.
module mon_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic mon_in,
  output logic mon_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last_q;
  logic                   rise_q;

  // Shift mon_in through the synchronizer chain, keep one delayed copy of the
  // synchronized level and register the rising-edge pulse.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      sync_last_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], mon_in};
      sync_last_q <= sync_q[SYNC_STAGES-1];
      rise_q      <= sync_q[SYNC_STAGES-1] & ~sync_last_q;
    end
  end

  assign mon_rise = rise_q;

endmodule

// File: rtl/ice40_clock_ratio_monitor.sv
// Divided-clock ratio monitor. Samples a divided clock as data in the fast
// source-clock domain, times its rising edges in source cycles, compares the
// period with EXP_RATIO +/- TOL and reports period, lock and sticky error.
// Optional feature macro: CLOCK_MONITOR_MINMAX_EN adds period_min/period_max.
module ice40_clock_ratio_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned PW          = 8,
  parameter int unsigned EXP_RATIO   = 4,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic          mon_in,
  input  logic          enable,
  input  logic          clear,
  output logic [PW-1:0] period_out,
  output logic          period_valid,
  output logic          locked,
  output logic          err_sticky,
  output logic          stall
`ifdef CLOCK_MONITOR_MINMAX_EN
  ,
  output logic [PW-1:0] period_min,
  output logic [PW-1:0] period_max
`endif
);

  localparam logic [PW-1:0]        CntMax     = PW'(sat_max(PW));
  localparam logic [PW-1:0]        CntPreMax  = CntMax - PW'(1);
  localparam logic [PW:0]          ExpWide    = (PW+1)'(EXP_RATIO);
  localparam logic [PW:0]          TolWide    = (PW+1)'(TOL);
  localparam logic [MatchCntW-1:0] LockTarget = MatchCntW'(LOCK_COUNT);

  logic mon_rise;

  mon_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .mon_in   (mon_in),
    .mon_rise (mon_rise)
  );

  mon_state_e           state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [MatchCntW-1:0] match_cnt_q, match_cnt_d;
  logic [PW-1:0]        period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 stall_q, stall_d;
  logic                 err_set;

  logic [PW-1:0]        period_meas;
  logic [PW:0]          period_ext;
  logic [PW:0]          abs_diff;
  logic                 match;

  // Period of the interval ending at this edge (cnt+1, saturating) and its
  // distance from the expected ratio, one bit wider so it cannot wrap.
  always_comb begin
    period_meas = (cnt_q == CntMax) ? CntMax : cnt_q + PW'(1);
    period_ext  = {1'b0, period_meas};
    abs_diff    = (period_ext >= ExpWide) ? period_ext - ExpWide : ExpWide - period_ext;
    match       = (abs_diff <= TolWide);
  end

  // Next-state logic: FSM, edge counter, match counter and output strobes.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    stall_d     = 1'b0;
    err_set     = 1'b0;

    if (mon_rise) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + PW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (!enable) begin
      state_d     = StIdle;
      cnt_d       = '0;
      match_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d       = '0;
          match_cnt_d = '0;
          state_d     = StAcquire;
        end
        StAcquire: begin
          // First edge only starts the measurement; the interval before it is partial.
          match_cnt_d = '0;
          if (mon_rise) begin
            state_d = StMeasure;
          end
        end
        StMeasure, StLocked: begin
          if (mon_rise) begin
            // An edge coinciding with saturation still reports (2^PW-1, a mismatch).
            period_d = period_meas;
            valid_d  = 1'b1;
            if (match) begin
              if (state_q == StMeasure) begin
                match_cnt_d = match_cnt_q + MatchCntW'(1);
                if (match_cnt_q + MatchCntW'(1) == LockTarget) begin
                  state_d = StLocked;
                end
              end
            end else begin
              err_set     = 1'b1;
              match_cnt_d = '0;
              state_d     = StMeasure;
            end
          end else if (cnt_q == CntPreMax) begin
            // Counter saturates this cycle: the monitored clock has stopped.
            stall_d     = 1'b1;
            err_set     = 1'b1;
            match_cnt_d = '0;
            state_d     = StAcquire;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // A new error beats a simultaneous clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
    end
  end

  // locked follows the state register so an asynchronous reset drops it at once.
  assign locked       = (state_q == StLocked);
  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign err_sticky   = err_q;
  assign stall        = stall_q;

`ifdef CLOCK_MONITOR_MINMAX_EN
  logic [PW-1:0] min_q, min_d, min_base;
  logic [PW-1:0] max_q, max_d, max_base;

  // Extremes tracker; clear restarts from the empty range, then the period
  // reported in the same cycle (if any) is folded in.
  always_comb begin
    min_base = clear ? CntMax : min_q;
    max_base = clear ? '0 : max_q;
    min_d    = min_base;
    max_d    = max_base;
    if (valid_d) begin
      if (period_d < min_base) begin
        min_d = period_d;
      end
      if (period_d > max_base) begin
        max_d = period_d;
      end
    end
  end

  // Min/max registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= CntMax;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign period_min = min_q;
  assign period_max = max_q;
`endif

endmodule

// File: tb/tb_ice40_clock_ratio_monitor.sv
// Directed self-checking bench for ice40_clock_ratio_monitor. A default
// instance (ratio 4) covers lock, mismatch, clear, stall, enable and reset;
// a second instance with EXP_RATIO=2 covers the fastest legal period.
module tb_ice40_clock_ratio_monitor;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b0;
  logic       mon_in   = 1'b0;
  logic       enable   = 1'b0;
  logic       clear    = 1'b0;
  logic [7:0] period_out;
  logic       period_valid, locked, err_sticky, stall;

  logic       mon2    = 1'b0;
  logic       enable2 = 1'b0;
  logic       clear2  = 1'b0;
  logic [7:0] period_out2;
  logic       period_valid2, locked2, err_sticky2, stall2;

`ifdef CLOCK_MONITOR_MINMAX_EN
  logic [7:0] period_min, period_max, period_min2, period_max2;
`endif

  int checks = 0;
  int errors = 0;

  int pv_vals[$];
  bit pv_lock[$];
  int pv2_vals[$];
  bit pv2_lock[$];
  int stall_cnt = 0;

  always #5 clock_in = ~clock_in;

  ice40_clock_ratio_monitor dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .mon_in       (mon_in),
    .enable       (enable),
    .clear        (clear),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .err_sticky   (err_sticky),
    .stall        (stall)
`ifdef CLOCK_MONITOR_MINMAX_EN
    ,
    .period_min   (period_min),
    .period_max   (period_max)
`endif
  );

  ice40_clock_ratio_monitor #(
    .EXP_RATIO (2)
  ) dut2 (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .mon_in       (mon2),
    .enable       (enable2),
    .clear        (clear2),
    .period_out   (period_out2),
    .period_valid (period_valid2),
    .locked       (locked2),
    .err_sticky   (err_sticky2),
    .stall        (stall2)
`ifdef CLOCK_MONITOR_MINMAX_EN
    ,
    .period_min   (period_min2),
    .period_max   (period_max2)
`endif
  );

  // Record every reported period (with the lock flag seen alongside it).
  always @(posedge clock_in) begin
    #1;
    if (period_valid) begin
      pv_vals.push_back(int'(period_out));
      pv_lock.push_back(locked);
    end
    if (period_valid2) begin
      pv2_vals.push_back(int'(period_out2));
      pv2_lock.push_back(locked2);
    end
    if (stall) stall_cnt++;
  end

  task automatic tick();
    @(posedge clock_in);
    #2;
  endtask

  // One period of p source cycles starting with a rise; clear high at index clr_at.
  task automatic drive_period(input int p, input int clr_at);
    for (int i = 0; i < p; i++) begin
      mon_in = (i < p / 2);
      clear  = (i == clr_at);
      tick();
    end
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (period_out !== 8'd0) begin errors++; $display("FAIL reset_period_out: got %0d want 0", period_out); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_period_valid: got %b want 0", period_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_sticky); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef CLOCK_MONITOR_MINMAX_EN
    checks++; if (period_min !== 8'hff) begin errors++; $display("FAIL reset_min: got %0d want 255", period_min); end
    checks++; if (period_max !== 8'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", period_max); end
`endif
    reset_n = 1'b1;
    repeat (3) tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked: got %b want 0", locked); end
  endtask

  task automatic test_ratio2();
    int n0;
    enable2 = 1'b1;
    tick();
    tick();
    n0 = pv2_vals.size();
    for (int i = 0; i < 30; i++) begin
      mon2 = (i % 2 == 0);
      tick();
    end
    mon2 = 1'b0;
    repeat (3) tick();
    checks++; if (pv2_vals.size() - n0 !== 14) begin errors++; $display("FAIL ratio2_count: got %0d want 14", pv2_vals.size() - n0); end
    for (int i = n0; i < pv2_vals.size(); i++) begin
      checks++; if (pv2_vals[i] !== 2) begin errors++; $display("FAIL ratio2_period[%0d]: got %0d want 2", i - n0, pv2_vals[i]); end
    end
    checks++; if (pv2_lock[n0+2] !== 1'b0) begin errors++; $display("FAIL ratio2_lock_early: got %b want 0", pv2_lock[n0+2]); end
    checks++; if (pv2_lock[n0+3] !== 1'b1) begin errors++; $display("FAIL ratio2_lock_4th: got %b want 1", pv2_lock[n0+3]); end
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL ratio2_locked: got %b want 1", locked2); end
    checks++; if (err_sticky2 !== 1'b0) begin errors++; $display("FAIL ratio2_err: got %b want 0", err_sticky2); end
  endtask

  task automatic test_ratio4();
    int n0;
    enable = 1'b1;
    tick();
    tick();
    n0 = pv_vals.size();
    repeat (10) drive_period(4, -1);
    checks++; if (pv_vals.size() - n0 !== 9) begin errors++; $display("FAIL ratio4_count: got %0d want 9", pv_vals.size() - n0); end
    for (int i = n0; i < pv_vals.size(); i++) begin
      checks++; if (pv_vals[i] !== 4) begin errors++; $display("FAIL ratio4_period[%0d]: got %0d want 4", i - n0, pv_vals[i]); end
    end
    checks++; if (pv_lock[n0+2] !== 1'b0) begin errors++; $display("FAIL ratio4_lock_early: got %b want 0", pv_lock[n0+2]); end
    checks++; if (pv_lock[n0+3] !== 1'b1) begin errors++; $display("FAIL ratio4_lock_4th: got %b want 1", pv_lock[n0+3]); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ratio4_locked: got %b want 1", locked); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL ratio4_err: got %b want 0", err_sticky); end
  endtask

  task automatic test_mismatch();
    int n0;
    int exp_v[6] = '{4, 5, 4, 4, 4, 4};
    bit exp_l[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    n0 = pv_vals.size();
    drive_period(5, -1);
    repeat (5) drive_period(4, -1);
    checks++; if (pv_vals.size() - n0 !== 6) begin errors++; $display("FAIL mismatch_count: got %0d want 6", pv_vals.size() - n0); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (pv_vals[n0+i] !== exp_v[i]) begin errors++; $display("FAIL mismatch_period[%0d]: got %0d want %0d", i, pv_vals[n0+i], exp_v[i]); end
      checks++; if (pv_lock[n0+i] !== exp_l[i]) begin errors++; $display("FAIL mismatch_lock[%0d]: got %b want %b", i, pv_lock[n0+i], exp_l[i]); end
    end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL mismatch_err: got %b want 1", err_sticky); end
  endtask

  task automatic test_clear();
    drive_period(4, 3);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clear_alone_err: got %b want 0", err_sticky); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clear_alone_locked: got %b want 1", locked); end
    drive_period(6, -1);
    drive_period(4, 3);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL clear_collide_err: got %b want 1", err_sticky); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clear_collide_locked: got %b want 0", locked); end
    checks++; if (pv_vals[pv_vals.size()-1] !== 6) begin errors++; $display("FAIL clear_collide_period: got %0d want 6", pv_vals[pv_vals.size()-1]); end
    drive_period(4, 3);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clear_after_err: got %b want 0", err_sticky); end
  endtask

  task automatic test_stall();
    int n0;
    int s0;
    repeat (4) drive_period(4, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stall_prelock: got %b want 1", locked); end
    n0 = pv_vals.size();
    s0 = stall_cnt;
    mon_in = 1'b0;
    repeat (300) tick();
    checks++; if (stall_cnt - s0 !== 1) begin errors++; $display("FAIL stall_pulses: got %0d want 1", stall_cnt - s0); end
    checks++; if (pv_vals.size() - n0 !== 0) begin errors++; $display("FAIL stall_no_valid: got %0d want 0", pv_vals.size() - n0); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stall_locked: got %b want 0", locked); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL stall_err: got %b want 1", err_sticky); end
    n0 = pv_vals.size();
    repeat (6) drive_period(4, -1);
    checks++; if (pv_vals.size() - n0 !== 5) begin errors++; $display("FAIL restart_count: got %0d want 5", pv_vals.size() - n0); end
    checks++; if (pv_vals[n0] !== 4) begin errors++; $display("FAIL restart_first: got %0d want 4", pv_vals[n0]); end
    checks++; if (pv_lock[n0+2] !== 1'b0) begin errors++; $display("FAIL restart_lock_early: got %b want 0", pv_lock[n0+2]); end
    checks++; if (pv_lock[n0+3] !== 1'b1) begin errors++; $display("FAIL restart_lock_4th: got %b want 1", pv_lock[n0+3]); end
  endtask

`ifdef CLOCK_MONITOR_MINMAX_EN
  task automatic test_minmax();
    drive_period(4, 1);
    drive_period(3, -1);
    drive_period(6, -1);
    drive_period(4, -1);
    checks++; if (period_min !== 8'd3) begin errors++; $display("FAIL minmax_min: got %0d want 3", period_min); end
    checks++; if (period_max !== 8'd6) begin errors++; $display("FAIL minmax_max: got %0d want 6", period_max); end
  endtask
`endif

  task automatic test_enable();
    int n0;
    repeat (4) drive_period(4, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL enable_prelock: got %b want 1", locked); end
    enable = 1'b0;
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL enable_fall_locked: got %b want 0", locked); end
    n0 = pv_vals.size();
    repeat (3) drive_period(4, -1);
    checks++; if (pv_vals.size() - n0 !== 0) begin errors++; $display("FAIL disabled_valid: got %0d want 0", pv_vals.size() - n0); end
    enable = 1'b1;
    n0 = pv_vals.size();
    repeat (6) drive_period(4, -1);
    checks++; if (pv_vals.size() - n0 !== 5) begin errors++; $display("FAIL reenable_count: got %0d want 5", pv_vals.size() - n0); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reenable_locked: got %b want 1", locked); end
  endtask

  task automatic test_reset_midlock();
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked: got %b want 0", locked); end
    checks++; if (period_out !== 8'd0) begin errors++; $display("FAIL arst_period_out: got %0d want 0", period_out); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", err_sticky); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", period_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b want 0", stall); end
    checks++; if (err_sticky2 !== 1'b0) begin errors++; $display("FAIL arst_err2: got %b want 0", err_sticky2); end
`ifdef CLOCK_MONITOR_MINMAX_EN
    checks++; if (period_min !== 8'hff) begin errors++; $display("FAIL arst_min: got %0d want 255", period_min); end
    checks++; if (period_max !== 8'd0) begin errors++; $display("FAIL arst_max: got %0d want 0", period_max); end
`endif
  endtask

  initial begin
    test_reset();
    test_ratio2();
    test_ratio4();
    test_mismatch();
    test_clear();
    test_stall();
`ifdef CLOCK_MONITOR_MINMAX_EN
    test_minmax();
`endif
    test_enable();
    test_reset_midlock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
